// File: rtl/iq_pkg.sv
// Shared definitions for the IQ phase extractor: FSM states, guard widths
// and the CORDIC arctangent table.
package iq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOLD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } iq_state_t;

    // Extra integer bits on I/Q (CORDIC growth) and fractional bits on phase.
    localparam int XY_GUARD = 2;
    localparam int PH_GUARD = 4;
    localparam int ATAN_N   = 16;

    // atan(2^-k) with a full turn = 2^32, truncated to zw bits with rounding.
    function automatic logic [31:0] atan_scaled(input int k, input int zw);
        logic [31:0] t;
        case (k)
            0:       t = 32'h2000_0000;
            1:       t = 32'h12E4_051E;
            2:       t = 32'h09FB_385B;
            3:       t = 32'h0511_11D4;
            4:       t = 32'h028B_0D43;
            5:       t = 32'h0145_D7E1;
            6:       t = 32'h00A2_F61E;
            7:       t = 32'h0051_7C55;
            8:       t = 32'h0028_BE53;
            9:       t = 32'h0014_5F2F;
            10:      t = 32'h000A_2F98;
            11:      t = 32'h0005_17CC;
            12:      t = 32'h0002_8BE6;
            13:      t = 32'h0001_45F3;
            14:      t = 32'h0000_A2FA;
            15:      t = 32'h0000_517D;
            default: t = 32'h0000_0000;
        endcase
        t = t + (32'd1 << (31 - zw));
        return t >> (32 - zw);
    endfunction

endpackage

// File: rtl/iq_cordic_stage.sv
// One CORDIC vectoring micro-rotation: steers y toward zero and accumulates
// the rotated angle into z.
module iq_cordic_stage
    import iq_pkg::*;
#(
    parameter int XW = 19,
    parameter int ZW = 16,
    parameter int KW = 4
) (
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] y,
    input  logic        [ZW-1:0] z,
    input  logic        [KW-1:0] k,
    output logic signed [XW-1:0] x_n,
    output logic signed [XW-1:0] y_n,
    output logic        [ZW-1:0] z_n
);

    logic signed [XW-1:0] xs;
    logic signed [XW-1:0] ys;
    logic        [31:0]   a32;
    logic        [ZW-1:0] a;

    always_comb begin
        xs  = x >>> k;
        ys  = y >>> k;
        a32 = atan_scaled(int'(k), ZW);
        a   = a32[ZW-1:0];
        if (y[XW-1]) begin
            x_n = x - ys;
            y_n = y + xs;
            z_n = z - a;
        end else begin
            x_n = x + ys;
            y_n = y - xs;
            z_n = z + a;
        end
    end

endmodule

// File: rtl/iq_phase_extractor.sv
// Iterative CORDIC atan2/magnitude of an I/Q pair, one micro-rotation per i_ce.
// Define IQ_PHASE_MAG_EN to drive o_mag with the final CORDIC |X|; otherwise o_mag is 0.
module iq_phase_extractor
    import iq_pkg::*;
#(
    parameter int OW = 16,
    parameter int PW = 12
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ce,
    input  logic              i_valid,
    input  logic signed [OW:0] i_i,
    input  logic signed [OW:0] i_q,
    output logic              o_ready,
    output logic              o_valid,
    output logic [PW-1:0]     o_phase,
    output logic [OW+1:0]     o_mag
);

    localparam int XW = OW + 1 + XY_GUARD;
    localparam int ZW = PW + PH_GUARD;
    localparam int KW = $clog2(PW);
    localparam logic [ZW-1:0] HALF_TURN = ZW'(1) << (ZW - 1);

    iq_state_t            state;
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;
    logic        [ZW-1:0] z;
    logic        [KW-1:0] k;
    logic                 zero_in;
    logic signed [XW-1:0] x_n;
    logic signed [XW-1:0] y_n;
    logic        [ZW-1:0] z_n;
    logic                 last_iter;

    function automatic logic [PW-1:0] round_phase(input logic [ZW-1:0] zv);
        logic [ZW-1:0] t;
        t = zv + ZW'(1 << (PH_GUARD - 1));
        return t[ZW-1:PH_GUARD];
    endfunction

    iq_cordic_stage #(.XW(XW), .ZW(ZW), .KW(KW)) u_stage (
        .x  (x),
        .y  (y),
        .z  (z),
        .k  (k),
        .x_n(x_n),
        .y_n(y_n),
        .z_n(z_n)
    );

    assign o_ready   = (state == ST_IDLE) || (state == ST_DONE);
    assign o_valid   = (state == ST_DONE);
    assign last_iter = (k == KW'(PW - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            k       <= '0;
            zero_in <= 1'b0;
            o_phase <= '0;
        end else if (i_ce) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_valid) begin
                        x       <= {{XY_GUARD{i_i[OW]}}, i_i};
                        y       <= {{XY_GUARD{i_q[OW]}}, i_q};
                        zero_in <= (i_i == '0) && (i_q == '0);
                        state   <= ST_FOLD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                // Left half-plane is rotated by 180 degrees so CORDIC only
                // has to cover +/-90 degrees.
                ST_FOLD: begin
                    if (x[XW-1]) begin
                        x <= -x;
                        y <= -y;
                        z <= HALF_TURN;
                    end else begin
                        z <= '0;
                    end
                    k     <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    x <= x_n;
                    y <= y_n;
                    z <= z_n;
                    k <= k + 1'b1;
                    if (last_iter) begin
                        // A zero vector has no angle; report 0 instead of the
                        // sum of table entries the rotations would leave behind.
                        o_phase <= zero_in ? '0 : round_phase(z_n);
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IQ_PHASE_MAG_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_mag <= '0;
        end else if (i_ce && (state == ST_ITER) && last_iter) begin
            o_mag <= x_n[OW+1:0];
        end
    end
`else
    assign o_mag = '0;
`endif

endmodule

// File: tb/tb_iq_phase_extractor.sv
// Directed bench for iq_phase_extractor: quadrants, diagonal, edge cases,
// handshake timing, clock-enable freeze, reset mid-iteration and a full lookup round-trip.
module tb_iq_phase_extractor;

    localparam int OW = 16;
    localparam int PW = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic              vld;
    logic signed [OW:0] ii;
    logic signed [OW:0] qq;
    logic              rdy;
    logic              ov;
    logic [PW-1:0]     ph;
    logic [OW+1:0]     mag;

    int checks = 0;
    int errors = 0;
    bit tog = 1'b0;
    int ce_cnt = 0;
    int wall_cnt = 0;

    always #5 clk = ~clk;

    iq_phase_extractor #(.OW(OW), .PW(PW)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .i_ce   (ce),
        .i_valid(vld),
        .i_i    (ii),
        .i_q    (qq),
        .o_ready(rdy),
        .o_valid(ov),
        .o_phase(ph),
        .o_mag  (mag)
    );

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        checks++;
        assert ((d <= tol) === 1'b1)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic chk_ph(input string tag, input int obs, input int exp);
        int d;
        d = (((obs - exp) % 4096) + 4096) % 4096;
        if (d > 2048) d = 4096 - d;
        checks++;
        assert ((d <= 1) === 1'b1)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+/-1", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        bit ce_at_edge;
        ce_at_edge = ce;
        @(posedge clk);
        @(negedge clk);
        if (ce_at_edge) ce_cnt++;
        wall_cnt++;
        if (tog) ce = ~ce;
    endtask

    task automatic run(input int i, input int q, output int p, output int m,
                       output int lat_ce, output int lat_wall, output int to);
        int guard;
        guard = 0;
        to = 0;
        while (!(rdy && ce) && guard < 40) begin
            tick();
            guard++;
        end
        ii = (OW+1)'(i);
        qq = (OW+1)'(q);
        vld = 1'b1;
        ce_cnt = 0;
        wall_cnt = 0;
        tick();
        vld = 1'b0;
        while (!ov && wall_cnt < 100) tick();
        if (!ov) to = 1;
        p = int'(ph);
        m = int'(mag);
        lat_ce = ce_cnt;
        lat_wall = wall_cnt;
    endtask

    initial begin
        int p, m, lc, lw, to, pulses, prev, hi_run, nvalid;
        int qi [4];
        int qqv [4];
        int qe [4];
        real a;
        int ci, si;

        qi  = '{16384, 0, -16384, 0};
        qqv = '{0, 16384, 0, -16384};
        qe  = '{0, 1024, 2048, 3072};

        rst = 1'b1;
        ce  = 1'b1;
        vld = 1'b0;
        ii  = '0;
        qq  = '0;
        @(negedge clk);
        @(negedge clk);
        chk_eq("reset_valid", int'(ov), 0);
        chk_eq("reset_phase", int'(ph), 0);
        chk_eq("reset_mag", int'(mag), 0);
        rst = 1'b0;
        tick();
        chk_eq("ready_after_reset", int'(rdy), 1);

        // Quadrant points with latency.
        for (int n = 0; n < 4; n++) begin
            run(qi[n], qqv[n], p, m, lc, lw, to);
            chk_eq("quad_timeout", to, 0);
            chk_ph($sformatf("quad_phase_%0d", n), p, qe[n]);
            chk_eq("quad_latency", lc, PW + 2);
            tick();
            chk_eq("quad_valid_one_cycle", int'(ov), 0);
        end

        // Diagonal.
        run(11585, 11585, p, m, lc, lw, to);
        chk_ph("diag_phase", p, 512);
`ifdef IQ_PHASE_MAG_EN
        chk_tol("diag_mag", m, 26981, 2);
`else
        chk_eq("diag_mag_off", m, 0);
`endif
        // Results hold while idle.
        for (int n = 0; n < 5; n++) tick();
        chk_ph("diag_phase_held", int'(ph), 512);

        // Edge cases.
        run(-65536, 0, p, m, lc, lw, to);
        chk_ph("fullscale_neg_phase", p, 2048);
`ifdef IQ_PHASE_MAG_EN
        chk_tol("fullscale_neg_mag", m, 107923, 16);
`endif
        run(0, 0, p, m, lc, lw, to);
        chk_eq("zero_phase", p, 0);
        chk_eq("zero_mag", m, 0);

        // 50% clock enable: same result, double wall time, o_valid frozen.
        tog = 1'b1;
        ce = 1'b1;
        run(11585, 11585, p, m, lc, lw, to);
        chk_ph("ce_half_phase", p, 512);
        chk_eq("ce_half_latency_ce", lc, PW + 2);
        chk_eq("ce_half_latency_wall", lw, 2 * (PW + 2) - 1);
        chk_eq("ce_half_ce_low", int'(ce), 0);
        tick();
        chk_eq("ce_freeze_valid", int'(ov), 1);
        tick();
        chk_eq("ce_release_valid", int'(ov), 0);
        tog = 1'b0;
        ce = 1'b1;

        // Continuous i_valid: one accept and one o_valid pulse every PW+2 cycles.
        ii = (OW+1)'(0);
        qq = (OW+1)'(16384);
        vld = 1'b1;
        pulses = 0;
        prev = -1;
        hi_run = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (ov) begin
                hi_run++;
                pulses++;
                if (prev >= 0) chk_eq("b2b_period", n - prev, PW + 2);
                chk_ph("b2b_phase", int'(ph), 1024);
                prev = n;
            end else begin
                hi_run = 0;
            end
            if (hi_run > 1) chk_eq("b2b_pulse_width", hi_run, 1);
        end
        chk_eq("b2b_pulse_count", pulses, 4);
        vld = 1'b0;
        for (int n = 0; n < 20; n++) tick();

        // Reset at iteration 5 of an in-flight sample.
        run(16384, 0, p, m, lc, lw, to);
        ii = (OW+1)'(0);
        qq = (OW+1)'(16384);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        for (int n = 0; n < 6; n++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk_eq("midreset_valid", int'(ov), 0);
        chk_eq("midreset_phase", int'(ph), 0);
        chk_eq("midreset_mag", int'(mag), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_eq("midreset_ready", int'(rdy), 1);
        nvalid = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (ov) nvalid++;
        end
        chk_eq("midreset_no_valid", nvalid, 0);
        chk_eq("midreset_phase_after", int'(ph), 0);

        // Round trip through a sine/cosine lookup.
        for (int n = 0; n < 4096; n++) begin
            a  = 2.0 * 3.14159265358979 * real'(n) / 4096.0;
            ci = $rtoi($floor(16384.0 * $cos(a) + 0.5));
            si = $rtoi($floor(16384.0 * $sin(a) + 0.5));
            run(ci, si, p, m, lc, lw, to);
            if (to != 0) chk_eq("roundtrip_timeout", to, 0);
            chk_ph($sformatf("roundtrip_%0d", n), p, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_phase_extractor.md
IQ_PHASE_EXTRACTOR -- requirements
Module: iq_phase_extractor

Interface
REQ-001 SHALL have parameter OW, default 16, meaning sample magnitude width; samples are signed OW+1 bits.
REQ-002 SHALL have parameter PW, default 12, meaning phase width; full circle = 2^PW counts.
REQ-003 SHALL have input i_clk, 1 bit, the clock.
REQ-004 SHALL have input i_reset, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have input i_ce, 1 bit, clock enable; all state advances only when i_ce=1.
REQ-006 SHALL have input i_valid, 1 bit, input sample pair valid.
REQ-007 SHALL have inputs i_i and i_q, each signed OW+1 bits: in-phase (cos) and quadrature (sin) components.
REQ-008 SHALL have output o_ready, 1 bit, block can accept a sample this cycle.
REQ-009 SHALL have output o_valid, 1 bit, o_phase/o_mag valid this cycle.
REQ-010 SHALL have output o_phase, unsigned PW bits: atan2(i_q,i_i) scaled to 2^PW counts per turn, wrapped to [0, 2^PW-1].
REQ-011 SHALL have output o_mag, unsigned OW+2 bits: CORDIC magnitude (gain ~1.6468, uncompensated).

Function
REQ-012 SHALL use the same phase convention as the sine lookup: sample = sin(2*pi*phase/2^PW) on Q, cos on I, so a lookup round-trip returns the original phase within ±1 LSB.
REQ-013 SHALL implement FSM states IDLE, FOLD, ITER, DONE; all transitions gated by i_ce.
REQ-014 SHALL assert o_ready in IDLE and DONE only.
REQ-015 SHALL accept a sample when o_ready & i_valid & i_ce; it is registered, sign-extended by 2 bits, and the FSM goes to FOLD.
REQ-016 SHALL in FOLD, if I<0, negate both I and Q and preload internal phase with 2^(PW-1); else preload 0; go to ITER.
REQ-017 SHALL in ITER perform one CORDIC vectoring micro-rotation per i_ce cycle, k = 0..PW-1, driving Q toward 0, adding/subtracting atan(2^-k) from the internal phase accumulator.
REQ-018 SHALL keep the internal phase accumulator PW+4 bits wide, and round to nearest, wrapping modulo 2^PW, on entry to DONE.
REQ-019 SHALL in DONE assert o_valid for exactly one i_ce-qualified cycle, then return to IDLE, or to FOLD if a new sample is accepted that same cycle.
REQ-020 SHALL have fixed latency PW+2 i_ce cycles from the accept cycle to o_valid; back-to-back throughput is one sample per PW+2 i_ce cycles.
REQ-021 SHALL ignore i_valid while o_ready=0; no queuing.
REQ-022 SHALL hold o_phase and o_mag stable between results.
REQ-023 SHALL produce o_phase=0 and o_mag=0 for I=Q=0.
REQ-024 SHALL process full-scale I=-2^OW without overflow.
REQ-025 SHALL freeze all state, including an in-progress o_valid, while i_ce=0.

Reset
REQ-026 SHALL on i_reset, asynchronously and including mid-operation, force state IDLE, o_valid=0, o_phase=0, o_mag=0, accumulators=0, and discard any in-flight sample.
REQ-027 SHALL raise o_ready on the first clock after reset release.

Configuration
REQ-028 SHALL use macro IQ_PHASE_MAG_EN; when defined, o_mag carries the final CORDIC |X|.
REQ-029 SHALL, when IQ_PHASE_MAG_EN is undefined, tie o_mag to 0, remove the magnitude output register, and leave phase behaviour and latency unchanged.

Structure
REQ-030 SHALL take the FSM state enum, the atan(2^-k) constant table (PW+4-bit scaled), and the guard-bit constants from shared package iq_pkg.
REQ-031 SHALL place one combinational micro-rotation in sub-module iq_cordic_stage (inputs x, y, z, k; outputs x', y', z'), instantiated once and reused across iterations.

Verification (PW=12, OW=16, tolerance ±1 LSB)
REQ-032 SHALL cover quadrant points: (I,Q) = (16384,0) -> 0; (0,16384) -> 1024; (-16384,0) -> 2048; (0,-16384) -> 3072.
REQ-033 SHALL cover the diagonal: (11585,11585) -> 512, and with IQ_PHASE_MAG_EN, o_mag ≈ 26981 ±2.
REQ-034 SHALL cover round-trip: sweep phase 0..4095 through the sine lookup (cos via phase+1024) into this block -> o_phase = input phase ±1, including wrap at 4095/0.
REQ-035 SHALL cover handshake: i_valid held high continuously -> accepts exactly every 14 ce cycles; o_valid one cycle each; i_ce toggled 50% -> same results, double wall time.
REQ-036 SHALL cover reset mid-ITER: assert i_reset at iteration 5 -> o_valid never pulses, outputs 0, o_ready high next cycle.
REQ-037 SHALL cover edge cases: (-65536,0) -> 2048 with no overflow; (0,0) -> o_phase 0, o_mag 0.
